// File: rtl/ps2_kbd_display.sv
// PS/2 keyboard receiver with an 8-entry byte FIFO and a scan-code display.
// Shows the current key code as two hex digits and the key-press count as two decimal digits.
module ps2_kbd_display #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic [6:0] seg_code_lo,
  output logic [6:0] seg_code_hi,
  output logic [6:0] seg_cnt_lo,
  output logic [6:0] seg_cnt_hi
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic {IDLE, BRK} disp_state_t;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Synchronisers idle high so reset never fakes a falling edge.
  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic [3:0]             bit_cnt_reg;
  logic [9:0]             shift_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
    end
  end

  logic ps2_fall;
  logic bit_in;
  logic frame_ok;
  assign ps2_fall = clk_sync_reg[SYNC_STAGES-1] & ~clk_sync_reg[SYNC_STAGES-2];
  assign bit_in   = data_sync_reg[SYNC_STAGES-1];
  // shift_reg[0] is the start bit, [8:1] the byte, [9] the odd parity bit.
  assign frame_ok = ps2_fall && (bit_cnt_reg == 4'd10) && !shift_reg[0] && bit_in
                    && (^shift_reg[9:1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else if (ps2_fall) begin
      shift_reg   <= {bit_in, shift_reg[9:1]};
      bit_cnt_reg <= (bit_cnt_reg == 4'd10) ? 4'd0 : bit_cnt_reg + 4'd1;
    end
  end

  logic [7:0]    mem_reg [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic          full;
  logic          wr_do;
  logic          pop;

  assign full     = (count_reg == FULL_CNT);
  assign ready    = (count_reg != '0);
  assign pop      = ready && !nextdata_n;
  assign wr_do    = frame_ok && !full;
  assign data     = mem_reg[rd_ptr_reg];
  assign overflow = overflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          mem_reg[gi] <= '0;
        else if (wr_do && wr_ptr_reg == AW'(gi))
          mem_reg[gi] <= shift_reg[8:1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_do)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_do, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (frame_ok && full)
        overflow_reg <= 1'b1;
    end
  end

  disp_state_t state_reg;
  logic        key_active_reg;
  logic [7:0]  code_reg;
  logic [3:0]  cnt_lo_reg;
  logic [3:0]  cnt_hi_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      key_active_reg <= 1'b0;
      code_reg       <= '0;
      cnt_lo_reg     <= '0;
      cnt_hi_reg     <= '0;
    end else if (pop) begin
      if (data == 8'hE0) begin
        state_reg <= state_reg;
      end else if (data == 8'hF0) begin
        state_reg <= BRK;
      end else if (state_reg == BRK) begin
        state_reg <= IDLE;
        if (data == code_reg)
          key_active_reg <= 1'b0;
      end else if (!(data == code_reg && key_active_reg)) begin
        // New key press; typematic repeats of the held key fall through untouched.
        code_reg       <= data;
        key_active_reg <= 1'b1;
        if (cnt_lo_reg == 4'd9) begin
          cnt_lo_reg <= 4'd0;
          cnt_hi_reg <= (cnt_hi_reg == 4'd9) ? 4'd0 : cnt_hi_reg + 4'd1;
        end else begin
          cnt_lo_reg <= cnt_lo_reg + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_code_lo <= 7'h7F;
      seg_code_hi <= 7'h7F;
      seg_cnt_lo  <= 7'h40;
      seg_cnt_hi  <= 7'h40;
    end else begin
      seg_code_lo <= key_active_reg ? hex7(code_reg[3:0]) : 7'h7F;
      seg_code_hi <= key_active_reg ? hex7(code_reg[7:4]) : 7'h7F;
      seg_cnt_lo  <= hex7(cnt_lo_reg);
      seg_cnt_hi  <= hex7(cnt_hi_reg);
    end
  end

endmodule

// File: tb/tb_ps2_kbd_display.sv
// Directed bench for ps2_kbd_display: drives PS/2 frames and checks FIFO and digits.
`timescale 1ns/1ps
module tb_ps2_kbd_display;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic [6:0] seg_code_lo;
  logic [6:0] seg_code_hi;
  logic [6:0] seg_cnt_lo;
  logic [6:0] seg_cnt_hi;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pop_q[$];
  logic       auto_pop;
  logic       ready_seen;

  ps2_kbd_display #(.FIFO_DEPTH(8), .SYNC_STAGES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .seg_code_lo(seg_code_lo),
    .seg_code_hi(seg_code_hi),
    .seg_cnt_lo (seg_cnt_lo),
    .seg_cnt_hi (seg_cnt_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop consumer: request a pop of the head at the next rising edge and log it.
  always @(negedge clk) begin
    if (ready)
      ready_seen = 1'b1;
    if (auto_pop && ready) begin
      pop_q.push_back(data);
      nextdata_n = 1'b0;
    end else begin
      nextdata_n = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send the first nbits bits of a frame, LSB first, device-side timing.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      #10 ps2_clk = 1'b0;
      #50 ps2_clk = 1'b1;
      #40;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic check_digits(input string tag, input logic [6:0] ch, input logic [6:0] cl,
                              input logic [6:0] nh, input logic [6:0] nl);
    check({tag, ".code_hi"}, 32'(seg_code_hi), 32'(ch));
    check({tag, ".code_lo"}, 32'(seg_code_lo), 32'(cl));
    check({tag, ".cnt_hi"},  32'(seg_cnt_hi),  32'(nh));
    check({tag, ".cnt_lo"},  32'(seg_cnt_lo),  32'(nl));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".ready"},    32'(ready),    32'h0);
    check({tag, ".data"},     32'(data),     32'h00);
    check({tag, ".overflow"}, 32'(overflow), 32'h0);
    check_digits(tag, 7'h7F, 7'h7F, 7'h40, 7'h40);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; auto_pop = 1'b0;
    nextdata_n = 1'b1; ready_seen = 1'b0;
    settle(4);
    check_reset("reset");
    rst = 1'b0;
    settle(4);

    // Single make code
    auto_pop = 1'b1;
    pop_q.delete();
    send(8'h1C);
    settle(15);
    check("t1.pops", 32'(pop_q.size()), 32'd1);
    check("t1.byte", 32'(pop_q[0]), 32'h1C);
    check("t1.ready", 32'(ready), 32'h0);
    check_digits("t1", 7'h79, 7'h46, 7'h40, 7'h79);

    // Break of the held key blanks the code
    pop_q.delete();
    send(8'hF0);
    send(8'h1C);
    settle(15);
    check("t2.pops", 32'(pop_q.size()), 32'd2);
    check("t2.byte0", 32'(pop_q[0]), 32'hF0);
    check("t2.byte1", 32'(pop_q[1]), 32'h1C);
    check_digits("t2", 7'h7F, 7'h7F, 7'h40, 7'h79);

    // Typematic repeats count once
    for (int i = 0; i < 3; i++) begin
      send(8'h1B);
      #20;
    end
    settle(15);
    check_digits("t3.make", 7'h79, 7'h03, 7'h40, 7'h24);
    send(8'hF0);
    send(8'h1B);
    settle(15);
    check_digits("t3.break", 7'h7F, 7'h7F, 7'h40, 7'h24);

    // Overflow: nine frames into an eight-entry FIFO
    auto_pop = 1'b0;
    pop_q.delete();
    for (int i = 1; i <= 9; i++)
      send(8'(i));
    settle(10);
    check("t4.overflow", 32'(overflow), 32'h1);
    check("t4.ready", 32'(ready), 32'h1);
    check("t4.head", 32'(data), 32'h01);
    auto_pop = 1'b1;
    settle(30);
    check("t4.pops", 32'(pop_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t4.byte%0d", i), 32'(pop_q[i]), 32'(i + 1));
    check("t4.ready_after", 32'(ready), 32'h0);
    check("t4.overflow_sticky", 32'(overflow), 32'h1);
    check_digits("t4", 7'h40, 7'h00, 7'h79, 7'h40);

    // Corrupt frames are discarded
    pop_q.delete();
    ready_seen = 1'b0;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    settle(15);
    check("t5.ready_seen", 32'(ready_seen), 32'h0);
    check("t5.pops", 32'(pop_q.size()), 32'd0);
    check_digits("t5", 7'h40, 7'h00, 7'h79, 7'h40);

    // Count wrap over 100 distinct key presses from reset
    rst = 1'b1;
    settle(2);
    check_reset("t6.reset");
    rst = 1'b0;
    settle(2);
    for (int i = 1; i <= 99; i++) begin
      send(8'(i));
      send(8'hF0);
      send(8'(i));
    end
    settle(15);
    check_digits("t6.99", 7'h7F, 7'h7F, 7'h10, 7'h10);
    send(8'h64);
    send(8'hF0);
    send(8'h64);
    settle(15);
    check_digits("t6.100", 7'h7F, 7'h7F, 7'h40, 7'h40);
    send(8'h5A);
    settle(15);
    check_digits("t6.5A", 7'h12, 7'h08, 7'h40, 7'h79);

    // Reset in the middle of a frame
    send_frame(8'h33, 1'b0, 1'b0, 5);
    #3 rst = 1'b1;
    settle(3);
    check_reset("t7.reset");
    rst = 1'b0;
    settle(3);
    pop_q.delete();
    send(8'h1C);
    settle(15);
    check("t7.pops", 32'(pop_q.size()), 32'd1);
    check("t7.byte", 32'(pop_q[0]), 32'h1C);
    check_digits("t7", 7'h79, 7'h46, 7'h40, 7'h79);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
